is_launch_scheduler: RTL and testbench

Dual-issue launch scheduler between the issue FIFO and the register-read stage. Each cycle it inspects the two oldest FIFO entries and decides how many to launch. It raises exactly one of the double, single or zero launch flags, which the FIFO consumes to advance its read pointer. It also holds a per-register result-latency scoreboard and the divider-occupancy state machine.

---
 rtl/is_launch_scheduler_if.sv | 49 ++++
 rtl/is_launch_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_is_launch_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/is_launch_scheduler_if.sv
// Issue-FIFO head bundle: two candidate entries toward the
// scheduler and the one-hot launch flags back to the FIFO.
interface is_launch_scheduler_if;
  logic       line1_valid_i;
  logic [2:0] line1_class_i;
  logic [4:0] line1_rd_i;
  logic [4:0] line1_rj_i;
  logic [4:0] line1_rk_i;
  logic       line1_rd_we_i;
  logic       line1_rj_re_i;
  logic       line1_rk_re_i;

  logic       line2_valid_i;
  logic [2:0] line2_class_i;
  logic [4:0] line2_rd_i;
  logic [4:0] line2_rj_i;
  logic [4:0] line2_rk_i;
  logic       line2_rd_we_i;
  logic       line2_rj_re_i;
  logic       line2_rk_re_i;

  logic       double_valid_inst_lunch_flag_o;
  logic       single_valid_inst_lunch_flag_o;
  logic       zero_valid_inst_lunch_flag_o;

  modport master (
    output line1_valid_i, line1_class_i,
    output line1_rd_i, line1_rj_i, line1_rk_i,
    output line1_rd_we_i, line1_rj_re_i, line1_rk_re_i,
    output line2_valid_i, line2_class_i,
    output line2_rd_i, line2_rj_i, line2_rk_i,
    output line2_rd_we_i, line2_rj_re_i, line2_rk_re_i,
    input  double_valid_inst_lunch_flag_o,
    input  single_valid_inst_lunch_flag_o,
    input  zero_valid_inst_lunch_flag_o
  );

  modport slave (
    input  line1_valid_i, line1_class_i,
    input  line1_rd_i, line1_rj_i, line1_rk_i,
    input  line1_rd_we_i, line1_rj_re_i, line1_rk_re_i,
    input  line2_valid_i, line2_class_i,
    input  line2_rd_i, line2_rj_i, line2_rk_i,
    input  line2_rd_we_i, line2_rj_re_i, line2_rk_re_i,
    output double_valid_inst_lunch_flag_o,
    output single_valid_inst_lunch_flag_o,
    output zero_valid_inst_lunch_flag_o
  );
endinterface

// File: rtl/is_launch_scheduler.sv
// Dual-issue launch scheduler: pairing rules, per-register
// result-latency scoreboard and divider occupancy FSM.
module is_launch_scheduler #(
  parameter int DOUBLE_LAUNCH = 1,
  parameter int LOAD_USE_LAT  = 1,
  parameter int MUL_LAT       = 1,
  parameter int DIV_CYCLES    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 next_allowin_i,
  is_launch_scheduler_if.slave fifo,
  output logic                 div_busy_o,
  output logic                 div_cancel_o
);

  localparam int DW = $clog2(DIV_CYCLES);
  localparam logic [DW-1:0] DIV_INIT = DW'(DIV_CYCLES - 1);
  localparam logic [2:0] LD_INIT  = 3'(LOAD_USE_LAT);
  localparam logic [2:0] MUL_INIT = 3'(MUL_LAT);

  typedef enum logic {IDLE, BUSY} div_st_e;

  typedef struct packed {
    logic ld;
    logic st;
    logic mul;
    logic div;
    logic priv;
  } cls_t;

  function automatic cls_t dec(input logic [2:0] c);
    cls_t d;
    d = '0;
    unique case (c)
      3'd2:    d.ld   = 1'b1;
      3'd3:    d.st   = 1'b1;
      3'd4:    d.mul  = 1'b1;
      3'd5:    d.div  = 1'b1;
      3'd6:    d.priv = 1'b1;
      default: d      = '0;
    endcase
    return d;
  endfunction

  div_st_e       state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]    div_rd_q, div_rd_d;
  logic [2:0]    cnt_q [32];
  logic [2:0]    cnt_d [32];
  logic [31:0]   hold_q, hold_d;
  logic [31:0]   busy_vec;

  cls_t       d1, d2;
  logic       br1;
  logic       src1_busy, src2_busy;
  logic       raw, waw, pair_ok;
  logic       l1_go, l2_go;
  logic       wr1, wr2;
  logic       div_idle, div_go, div_done;
  logic [4:0] div_rd_new;

  assign d1  = dec(fifo.line1_class_i);
  assign d2  = dec(fifo.line2_class_i);
  assign br1 = (fifo.line1_class_i == 3'd1);

  // r0 is never busy: bit 0 stays clear
  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < 32; r++) begin
      busy_vec[r] = (cnt_q[r] != 3'd0) || hold_q[r];
    end
  end

  assign src1_busy =
    (fifo.line1_rj_re_i & busy_vec[fifo.line1_rj_i]) |
    (fifo.line1_rk_re_i & busy_vec[fifo.line1_rk_i]);

  assign src2_busy =
    (fifo.line2_rj_re_i & busy_vec[fifo.line2_rj_i]) |
    (fifo.line2_rk_re_i & busy_vec[fifo.line2_rk_i]);

  assign raw = fifo.line1_rd_we_i &
    (fifo.line1_rd_i != 5'd0) &
    ((fifo.line2_rj_re_i &
      (fifo.line2_rj_i == fifo.line1_rd_i)) |
     (fifo.line2_rk_re_i &
      (fifo.line2_rk_i == fifo.line1_rd_i)));

  assign waw = fifo.line1_rd_we_i & fifo.line2_rd_we_i &
    (fifo.line1_rd_i == fifo.line2_rd_i) &
    (fifo.line1_rd_i != 5'd0);

  assign div_idle = (state_q == IDLE);

  assign pair_ok = ~br1 & ~d1.priv & ~d2.priv &
    ~((d1.ld | d1.st) & (d2.ld | d2.st)) &
    ~((d1.mul | d1.div) & (d2.mul | d2.div)) &
    ~(d2.div & ~div_idle);

  assign l1_go = reset & fifo.line1_valid_i &
    next_allowin_i & ~flush_i & ~src1_busy &
    ~(d1.div & ~div_idle);

  assign l2_go = (DOUBLE_LAUNCH != 0) & l1_go &
    fifo.line2_valid_i & ~src2_busy &
    ~raw & ~waw & pair_ok;

  assign fifo.double_valid_inst_lunch_flag_o = l1_go & l2_go;
  assign fifo.single_valid_inst_lunch_flag_o = l1_go & ~l2_go;
  assign fifo.zero_valid_inst_lunch_flag_o   = ~l1_go;

  assign wr1 = l1_go & fifo.line1_rd_we_i &
    (fifo.line1_rd_i != 5'd0);
  assign wr2 = l2_go & fifo.line2_rd_we_i &
    (fifo.line2_rd_i != 5'd0);

  assign div_go   = (l1_go & d1.div) | (l2_go & d2.div);
  assign div_done = (state_q == BUSY) & (div_cnt_q == '0);

  // a non-writing divide still occupies the unit but holds no reg
  always_comb begin
    div_rd_new = 5'd0;
    if (l1_go & d1.div) begin
      if (fifo.line1_rd_we_i) div_rd_new = fifo.line1_rd_i;
    end else if (fifo.line2_rd_we_i) begin
      div_rd_new = fifo.line2_rd_i;
    end
  end

  assign div_busy_o   = reset & (state_q == BUSY);
  assign div_cancel_o = reset & flush_i & (state_q == BUSY);

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = (cnt_q[r] != 3'd0) ? cnt_q[r] - 3'd1 : 3'd0;
    end
    hold_d = hold_q;
    if (div_done) hold_d[div_rd_q] = 1'b0;
    if (wr1) begin
      if (d1.ld)  cnt_d[fifo.line1_rd_i]  = LD_INIT;
      if (d1.mul) cnt_d[fifo.line1_rd_i]  = MUL_INIT;
      if (d1.div) hold_d[fifo.line1_rd_i] = 1'b1;
    end
    if (wr2) begin
      if (d2.ld)  cnt_d[fifo.line2_rd_i]  = LD_INIT;
      if (d2.mul) cnt_d[fifo.line2_rd_i]  = MUL_INIT;
      if (d2.div) hold_d[fifo.line2_rd_i] = 1'b1;
    end
    if (flush_i) begin
      for (int r = 0; r < 32; r++) cnt_d[r] = 3'd0;
      hold_d = '0;
    end
    cnt_d[0]  = 3'd0;
    hold_d[0] = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    div_rd_d  = div_rd_q;
    unique case (state_q)
      IDLE: begin
        if (div_go) begin
          state_d   = BUSY;
          div_cnt_d = DIV_INIT;
          div_rd_d  = div_rd_new;
        end
      end
      BUSY: begin
        if (div_cnt_q == '0) state_d = IDLE;
        else div_cnt_d = div_cnt_q - 1'b1;
      end
    endcase
    if (flush_i) begin
      state_d   = IDLE;
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= 3'd0;
      hold_q    <= '0;
      state_q   <= IDLE;
      div_cnt_q <= '0;
      div_rd_q  <= 5'd0;
    end else begin
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      div_rd_q  <= div_rd_d;
    end
  end

endmodule

// File: tb/tb_is_launch_scheduler.sv
// Bench for is_launch_scheduler: flag table, hand-written
// latency/divider sequences and a randomized timeline model.
module tb_is_launch_scheduler;

  localparam int LDL  = 1;
  localparam int MULL = 1;
  localparam int DIVC = 16;
  localparam logic [2:0] D = 3'b100;
  localparam logic [2:0] S = 3'b010;
  localparam logic [2:0] Z = 3'b001;

  typedef struct packed {
    logic       v;
    logic [2:0] c;
    logic [4:0] rd;
    logic [4:0] rj;
    logic [4:0] rk;
    logic       we;
    logic       jre;
    logic       kre;
  } ln_t;

  typedef struct {
    string      nm;
    ln_t        a;
    ln_t        b;
    logic       f;
    logic       al;
    logic [2:0] e0;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic allow = 1'b0;
  ln_t  la = '0;
  ln_t  lb = '0;
  logic [2:0] fl [2];
  logic bsy [2];
  logic cnl [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // timeline model: absolute cycle at which each thing frees up
  int crdy [2][32];
  int dfree [2];
  int drd [2];

  vec_t tbl [$];

  is_launch_scheduler_if ifs [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_if
    assign ifs[g].line1_valid_i = la.v;
    assign ifs[g].line1_class_i = la.c;
    assign ifs[g].line1_rd_i    = la.rd;
    assign ifs[g].line1_rj_i    = la.rj;
    assign ifs[g].line1_rk_i    = la.rk;
    assign ifs[g].line1_rd_we_i = la.we;
    assign ifs[g].line1_rj_re_i = la.jre;
    assign ifs[g].line1_rk_re_i = la.kre;
    assign ifs[g].line2_valid_i = lb.v;
    assign ifs[g].line2_class_i = lb.c;
    assign ifs[g].line2_rd_i    = lb.rd;
    assign ifs[g].line2_rj_i    = lb.rj;
    assign ifs[g].line2_rk_i    = lb.rk;
    assign ifs[g].line2_rd_we_i = lb.we;
    assign ifs[g].line2_rj_re_i = lb.jre;
    assign ifs[g].line2_rk_re_i = lb.kre;
    assign fl[g] = {ifs[g].double_valid_inst_lunch_flag_o,
                    ifs[g].single_valid_inst_lunch_flag_o,
                    ifs[g].zero_valid_inst_lunch_flag_o};
  end

  is_launch_scheduler #(
    .DOUBLE_LAUNCH(1), .LOAD_USE_LAT(LDL),
    .MUL_LAT(MULL), .DIV_CYCLES(DIVC)
  ) dut0 (
    .clk(clk), .reset(rst_n), .flush_i(flush),
    .next_allowin_i(allow), .fifo(ifs[0]),
    .div_busy_o(bsy[0]), .div_cancel_o(cnl[0])
  );

  is_launch_scheduler #(
    .DOUBLE_LAUNCH(0), .LOAD_USE_LAT(LDL),
    .MUL_LAT(MULL), .DIV_CYCLES(DIVC)
  ) dut1 (
    .clk(clk), .reset(rst_n), .flush_i(flush),
    .next_allowin_i(allow), .fifo(ifs[1]),
    .div_busy_o(bsy[1]), .div_cancel_o(cnl[1])
  );

  function automatic ln_t mk(int c, int rd, int rj, int rk,
                             bit we, bit jre, bit kre);
    ln_t x;
    x.v = 1'b1; x.c = 3'(c);
    x.rd = 5'(rd); x.rj = 5'(rj); x.rk = 5'(rk);
    x.we = we; x.jre = jre; x.kre = kre;
    return x;
  endfunction

  function automatic ln_t op(int c, int rd, int rj, int rk);
    return mk(c, rd, rj, rk, 1'b1, 1'b1, 1'b1);
  endfunction

  function automatic ln_t rl();
    ln_t x;
    x.v   = ($urandom_range(0, 99) < 85);
    x.c   = 3'($urandom_range(0, 7));
    if (x.c == 3'd5 && $urandom_range(0, 2) != 0) x.c = 3'd0;
    x.rd  = 5'($urandom_range(0, 7));
    x.rj  = 5'($urandom_range(0, 7));
    x.rk  = 5'($urandom_range(0, 7));
    x.we  = 1'($urandom_range(0, 1));
    x.jre = 1'($urandom_range(0, 1));
    x.kre = 1'($urandom_range(0, 1));
    return x;
  endfunction

  task automatic add(string nm, ln_t a, ln_t b,
                     logic f, logic al, logic [2:0] e0);
    vec_t v;
    v.nm = nm; v.a = a; v.b = b;
    v.f = f; v.al = al; v.e0 = e0;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(string nm, ln_t a, ln_t b,
                      logic f, logic al, logic r,
                      logic [2:0] ef, logic eb, logic ec);
    la = a; lb = b; flush = f; allow = al; rst_n = r;
    @(negedge clk);
    chk({nm, ".flags"},  8'(fl[0]),  8'(ef));
    chk({nm, ".busy"},   8'(bsy[0]), 8'(eb));
    chk({nm, ".cancel"}, 8'(cnl[0]), 8'(ec));
    tick();
  endtask

  function automatic bit rbusy(int i, int r);
    if (r == 0) return 1'b0;
    if (cyc < crdy[i][r]) return 1'b1;
    return (cyc < dfree[i]) && (drd[i] == r);
  endfunction

  function automatic bit srcb(int i, ln_t x);
    return (x.jre && rbusy(i, int'(x.rj))) ||
           (x.kre && rbusy(i, int'(x.rk)));
  endfunction

  function automatic bit is_mem(logic [2:0] c);
    return (c == 3'd2) || (c == 3'd3);
  endfunction

  function automatic bit is_md(logic [2:0] c);
    return (c == 3'd4) || (c == 3'd5);
  endfunction

  task automatic mclear(int i);
    for (int r = 0; r < 32; r++) crdy[i][r] = 0;
    dfree[i] = 0;
    drd[i]   = 0;
  endtask

  task automatic mlaunch(int i, ln_t x);
    if (x.we && x.rd != 5'd0) begin
      if (x.c == 3'd2) crdy[i][x.rd] = cyc + LDL + 1;
      if (x.c == 3'd4) crdy[i][x.rd] = cyc + MULL + 1;
    end
    if (x.c == 3'd5) begin
      dfree[i] = cyc + DIVC + 1;
      drd[i]   = x.we ? int'(x.rd) : 0;
    end
  endtask

  task automatic model(int i, ln_t a, ln_t b,
                       logic f, logic al, logic r, bit dl,
                       output logic [2:0] ef,
                       output logic eb, output logic ec);
    bit db, l1, l2, dep, same;
    if (!r) begin
      ef = Z; eb = 1'b0; ec = 1'b0;
      mclear(i);
      return;
    end
    db = (cyc < dfree[i]);
    eb = db;
    ec = f && db;
    l1 = a.v && al && !f && !srcb(i, a) && !(a.c == 3'd5 && db);
    dep = a.we && a.rd != 5'd0 &&
          ((b.jre && b.rj == a.rd) || (b.kre && b.rk == a.rd));
    same = a.we && b.we && a.rd == b.rd && a.rd != 5'd0;
    l2 = dl && l1 && b.v && !srcb(i, b) && !dep && !same &&
         a.c != 3'd1 && a.c != 3'd6 && b.c != 3'd6 &&
         !(is_mem(a.c) && is_mem(b.c)) &&
         !(is_md(a.c) && is_md(b.c)) &&
         !(b.c == 3'd5 && db);
    ef = (l1 && l2) ? D : (l1 ? S : Z);
    if (f) begin
      mclear(i);
    end else begin
      if (l1) mlaunch(i, a);
      if (l2) mlaunch(i, b);
    end
  endtask

  initial begin
    ln_t rd9, dv10, r10;

    // reset: outputs forced quiet even with a launchable pair
    step("rst0", op(0, 1, 2, 3), op(0, 4, 5, 6), 1'b0, 1'b1, 1'b0, Z, 1'b0, 1'b0);
    step("rst1", op(0, 1, 2, 3), op(0, 4, 5, 6), 1'b1, 1'b1, 1'b0, Z, 1'b0, 1'b0);

    add("alu_pair", op(0, 1, 2, 3), op(0, 4, 5, 6), 1'b0, 1'b1, D);
    add("raw_r7", op(0, 7, 1, 2), op(0, 8, 7, 3), 1'b0, 1'b1, S);
    add("raw_r0", op(0, 0, 1, 2), op(0, 8, 0, 0), 1'b0, 1'b1, D);
    add("raw_no_re", op(0, 7, 1, 2), mk(0, 8, 7, 3, 1, 0, 1), 1'b0, 1'b1, D);
    add("waw", op(0, 5, 1, 2), op(0, 5, 3, 4), 1'b0, 1'b1, S);
    add("ld_st", mk(2, 9, 1, 2, 0, 1, 1), mk(3, 0, 3, 4, 0, 1, 1), 1'b0, 1'b1, S);
    add("st_st", mk(3, 0, 1, 2, 0, 1, 1), mk(3, 0, 3, 4, 0, 1, 1), 1'b0, 1'b1, S);
    add("mul_mul", mk(4, 9, 1, 2, 0, 1, 1), mk(4, 10, 3, 4, 0, 1, 1), 1'b0, 1'b1, S);
    add("mul_ld", mk(4, 9, 1, 2, 0, 1, 1), mk(2, 10, 3, 4, 0, 1, 1), 1'b0, 1'b1, D);
    add("br_alu", mk(1, 0, 1, 2, 0, 1, 1), op(0, 4, 5, 6), 1'b0, 1'b1, S);
    add("alu_br", op(0, 4, 5, 6), mk(1, 0, 1, 2, 0, 1, 1), 1'b0, 1'b1, D);
    add("priv1", op(6, 4, 5, 6), op(0, 1, 2, 3), 1'b0, 1'b1, S);
    add("priv2", op(0, 1, 2, 3), op(6, 4, 5, 6), 1'b0, 1'b1, S);
    add("cls7", op(7, 1, 2, 3), op(7, 4, 5, 6), 1'b0, 1'b1, D);
    add("no_l1", '0, op(0, 4, 5, 6), 1'b0, 1'b1, Z);
    add("no_l2", op(0, 1, 2, 3), '0, 1'b0, 1'b1, S);
    add("no_allow", op(0, 1, 2, 3), op(0, 4, 5, 6), 1'b0, 1'b0, Z);
    add("flush", op(0, 1, 2, 3), op(0, 4, 5, 6), 1'b1, 1'b1, Z);

    foreach (tbl[k]) begin
      la = tbl[k].a; lb = tbl[k].b;
      flush = tbl[k].f; allow = tbl[k].al; rst_n = 1'b1;
      @(negedge clk);
      chk({tbl[k].nm, ".dl1"}, 8'(fl[0]), 8'(tbl[k].e0));
      chk({tbl[k].nm, ".dl0"}, 8'(fl[1]),
          8'((tbl[k].e0 == D) ? S : tbl[k].e0));
      tick();
    end

    step("ld_go",   op(2, 8, 1, 2),  '0, 1'b0, 1'b1, 1'b1, S, 1'b0, 1'b0);
    step("ld_hold", op(0, 12, 8, 3), '0, 1'b0, 1'b1, 1'b1, Z, 1'b0, 1'b0);
    step("ld_use",  op(0, 12, 8, 3), '0, 1'b0, 1'b1, 1'b1, S, 1'b0, 1'b0);

    step("ld2_go",  op(2, 8, 1, 2),  '0, 1'b0, 1'b1, 1'b1, S, 1'b0, 1'b0);
    step("stall",   op(0, 12, 8, 3), '0, 1'b0, 1'b0, 1'b1, Z, 1'b0, 1'b0);
    step("ld2_use", op(0, 12, 8, 3), '0, 1'b0, 1'b1, 1'b1, S, 1'b0, 1'b0);

    step("mul_go",   op(4, 13, 1, 2), '0, 1'b0, 1'b1, 1'b1, S, 1'b0, 1'b0);
    step("mul_hold", op(0, 12, 13, 1), '0, 1'b0, 1'b1, 1'b1, Z, 1'b0, 1'b0);
    step("mul_use",  op(0, 12, 13, 1), '0, 1'b0, 1'b1, 1'b1, S, 1'b0, 1'b0);

    rd9  = op(0, 11, 9, 1);
    dv10 = op(5, 10, 1, 2);
    step("div_go", op(5, 9, 1, 2), '0, 1'b0, 1'b1, 1'b1, S, 1'b0, 1'b0);
    for (int k = 1; k <= DIVC; k++) begin
      if (k % 2 == 1)
        step($sformatf("div2_held%0d", k), dv10, '0, 1'b0, 1'b1, 1'b1, Z, 1'b1, 1'b0);
      else
        step($sformatf("rd9_held%0d", k), rd9, dv10, 1'b0, 1'b1, 1'b1, Z, 1'b1, 1'b0);
    end
    step("div_free", rd9, dv10, 1'b0, 1'b1, 1'b1, D, 1'b0, 1'b0);

    r10 = op(0, 14, 10, 1);
    for (int k = 1; k <= 4; k++)
      step($sformatf("rd10_held%0d", k), r10, '0, 1'b0, 1'b1, 1'b1, Z, 1'b1, 1'b0);
    step("div_flush", r10, '0, 1'b1, 1'b1, 1'b1, Z, 1'b1, 1'b1);
    step("rd10_go",   r10, '0, 1'b0, 1'b1, 1'b1, S, 1'b0, 1'b0);

    step("flush_div", op(5, 9, 1, 2), '0, 1'b1, 1'b1, 1'b1, Z, 1'b0, 1'b0);
    step("div_again", op(5, 9, 1, 2), '0, 1'b0, 1'b1, 1'b1, S, 1'b0, 1'b0);
    step("busy_alu1", op(0, 1, 2, 3), '0, 1'b0, 1'b1, 1'b1, S, 1'b1, 1'b0);
    step("busy_alu2", op(0, 1, 2, 3), '0, 1'b0, 1'b1, 1'b1, S, 1'b1, 1'b0);
    step("rst_busy",  op(0, 1, 2, 3), '0, 1'b1, 1'b1, 1'b0, Z, 1'b0, 1'b0);
    step("div_post",  op(5, 9, 1, 2), '0, 1'b0, 1'b1, 1'b1, S, 1'b0, 1'b0);
    step("rd9_post",  rd9, '0, 1'b0, 1'b1, 1'b1, Z, 1'b1, 1'b0);
    step("flush2",    rd9, '0, 1'b1, 1'b1, 1'b1, Z, 1'b1, 1'b1);
    step("rd9_fl",    rd9, '0, 1'b0, 1'b1, 1'b1, S, 1'b0, 1'b0);

    for (int t = 0; t < 3000; t++) begin
      ln_t a, b;
      logic f, al, r;
      logic [2:0] ef;
      logic eb, ec;
      a  = rl();
      b  = rl();
      r  = (t == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      f  = ($urandom_range(0, 99) < 3);
      al = ($urandom_range(0, 99) < 85);
      la = a; lb = b; flush = f; allow = al; rst_n = r;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        model(i, a, b, f, al, r, (i == 0), ef, eb, ec);
        chk($sformatf("rnd%0d.flags%0d", t, i), 8'(fl[i]), 8'(ef));
        chk($sformatf("rnd%0d.busy%0d", t, i), 8'(bsy[i]), 8'(eb));
        chk($sformatf("rnd%0d.cancel%0d", t, i), 8'(cnl[i]), 8'(ec));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
